// File: rtl/fixed_to_bcd_formatter_pkg.sv
// Shared constants and state encoding for the Q16.16 to BCD display formatter.
package fixed_to_bcd_formatter_pkg;

   localparam int FIX_INT_BITS   = 16;
   localparam int FIX_FRAC_BITS  = 16;
   localparam int BCD_DIGIT_W    = 4;
   localparam int INT_BCD_DIGITS = 5;
   localparam int INT_BCD_W      = BCD_DIGIT_W * INT_BCD_DIGITS;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_INT  = 3'd2,
      ST_FRAC = 3'd3,
      ST_DONE = 3'd4
   } fmt_state_e;

endpackage

// File: rtl/fixed_to_bcd_formatter_bcd_dd_digit.sv
// Double-dabble correction cell: one BCD digit gets +3 when it would carry
// past 9 after the next left shift.
module bcd_dd_digit
   import fixed_to_bcd_formatter_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= BCD_DIGIT_W'(5)) digit_out = digit_in + BCD_DIGIT_W'(3);
   end

endmodule

// File: rtl/fixed_to_bcd_formatter.sv
// Signed Q16.16 to sign-magnitude BCD formatter: double-dabble integer part,
// multiply-by-10 fraction part (truncated), valid/ready on both sides.
//
//   state   | meaning
//   IDLE    | in_ready high, waiting for an input handshake
//   ABS     | take magnitude, seed integer and fraction working registers
//   INT     | 16 double-dabble iterations on the integer magnitude
//   FRAC    | FRAC_DIGITS multiply-by-10 steps, one digit per cycle
//   DONE    | out_valid high, outputs held until out_ready
module fixed_to_bcd_formatter
   import fixed_to_bcd_formatter_pkg::*;
#(
   parameter int FRAC_DIGITS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_neg,
   output logic [INT_BCD_W-1:0]       out_int_bcd,
   output logic [4*FRAC_DIGITS-1:0]   out_frac_bcd
);

   localparam int FW   = BCD_DIGIT_W * FRAC_DIGITS;
   localparam int DD_W = INT_BCD_W + FIX_INT_BITS;
   localparam int FF_W = FIX_FRAC_BITS + BCD_DIGIT_W;

   if (FRAC_DIGITS < 1 || FRAC_DIGITS > 5) begin : g_frac_digits_check
      $error("fixed_to_bcd_formatter: FRAC_DIGITS must be in 1..5");
   end

   fmt_state_e state_q, state_d;

   logic [31:0]          data_q;
   logic [31:0]          mag;
   logic                 neg_raw_q;
   logic [4:0]           cnt_q;
   logic [DD_W-1:0]      dd_q;
   logic [INT_BCD_W-1:0] bcd_adj;
   logic [FF_W-1:0]      frac_f_q;
   logic [FF_W-1:0]      frac_p;
   logic [FW-1:0]        frac_sr_q;
   logic [FW-1:0]        frac_sr_next;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)      state_d = ST_ABS;
         ST_ABS:                     state_d = ST_INT;
         ST_INT:  if (cnt_q == 5'd0) state_d = ST_FRAC;
         ST_FRAC: if (cnt_q == 5'd0) state_d = ST_DONE;
         ST_DONE: if (out_ready)     state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   for (genvar i = 0; i < INT_BCD_DIGITS; i++) begin : g_dd
      bcd_dd_digit u_dd (
         .digit_in  (dd_q[FIX_INT_BITS + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .digit_out (bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      mag          = data_q[31] ? (~data_q + 32'd1) : data_q;
      frac_p       = (frac_f_q << 3) + (frac_f_q << 1);
      // The oldest digit slides toward the MS nibble; the cast drops the overflow nibble.
      frac_sr_next = FW'({frac_sr_q, frac_p[FF_W-1:FIX_FRAC_BITS]});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q       <= '0;
         neg_raw_q    <= 1'b0;
         cnt_q        <= '0;
         dd_q         <= '0;
         frac_f_q     <= '0;
         frac_sr_q    <= '0;
         out_neg      <= 1'b0;
         out_int_bcd  <= '0;
         out_frac_bcd <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) data_q <= in_data;
            ST_ABS: begin
               neg_raw_q <= data_q[31];
               dd_q      <= {{INT_BCD_W{1'b0}}, mag[31:FIX_FRAC_BITS]};
               frac_f_q  <= {{BCD_DIGIT_W{1'b0}}, mag[FIX_FRAC_BITS-1:0]};
               frac_sr_q <= '0;
               cnt_q     <= 5'(FIX_INT_BITS - 1);
            end
            ST_INT: begin
               dd_q <= {bcd_adj, dd_q[FIX_INT_BITS-1:0]} << 1;
               if (cnt_q == 5'd0) cnt_q <= 5'(FRAC_DIGITS - 1);
               else               cnt_q <= cnt_q - 5'd1;
            end
            ST_FRAC: begin
               frac_sr_q <= frac_sr_next;
               frac_f_q  <= {{BCD_DIGIT_W{1'b0}}, frac_p[FIX_FRAC_BITS-1:0]};
               if (cnt_q == 5'd0) begin
                  out_int_bcd  <= dd_q[DD_W-1:FIX_INT_BITS];
                  out_frac_bcd <= frac_sr_next;
                  // A value that truncates to zero never shows a minus sign.
                  out_neg      <= neg_raw_q &
                                  ((dd_q[DD_W-1:FIX_INT_BITS] != '0) || (frac_sr_next != '0));
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_to_bcd_formatter.sv
// Scoreboard bench for fixed_to_bcd_formatter: expected results queued at input
// handshake, popped and compared when the formatter presents a result.
module tb_fixed_to_bcd_formatter;

   localparam int FRAC_DIGITS = 4;
   localparam int FW          = 4 * FRAC_DIGITS;

   typedef struct packed {
      logic          neg;
      logic [19:0]   ib;
      logic [FW-1:0] fb;
   } exp_t;

   typedef struct {
      logic [31:0]   data;
      logic          neg;
      logic [19:0]   ib;
      logic [FW-1:0] fb;
      int            hold;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_neg;
   logic [19:0]   out_int_bcd;
   logic [FW-1:0] out_frac_bcd;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fixed_to_bcd_formatter #(.FRAC_DIGITS(FRAC_DIGITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_neg      (out_neg),
      .out_int_bcd  (out_int_bcd),
      .out_frac_bcd (out_frac_bcd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference: decimal digits by division, fraction by repeated *10.
   function automatic exp_t model(input logic [31:0] d);
      exp_t        r;
      logic [31:0] m;
      int          iv;
      int          f;
      m  = d[31] ? (~d + 32'd1) : d;
      iv = int'(m[31:16]);
      f  = int'(m[15:0]);
      r  = '0;
      for (int i = 0; i < 5; i++) begin
         r.ib[4*i +: 4] = 4'(iv % 10);
         iv = iv / 10;
      end
      for (int i = 0; i < FRAC_DIGITS; i++) begin
         f = f * 10;
         r.fb[4*(FRAC_DIGITS-1-i) +: 4] = 4'(f / 65536);
         f = f % 65536;
      end
      r.neg = d[31] && (r.ib != 0 || r.fb != 0);
      return r;
   endfunction

   task automatic drive_input(input logic [31:0] d, input exp_t e);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_data  = d;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic collect(input int hold);
      int   lat;
      exp_t e;
      exp_t snap;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      // out_valid first seen after edge T+17+FD, i.e. sampled high at edge T+18+FD.
      check_eq("latency", 32'(lat), 32'(17 + FRAC_DIGITS));
      if (!out_valid) return;
      if (sb.size() == 0) begin
         check_eq("scoreboard_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check_eq("neg",  32'(out_neg),      32'(e.neg));
      check_eq("int",  32'(out_int_bcd),  32'(e.ib));
      check_eq("frac", 32'(out_frac_bcd), 32'(e.fb));
      snap = {out_neg, out_int_bcd, out_frac_bcd};
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         tick();
         check_eq("hold_stable", 32'({out_neg, out_int_bcd, out_frac_bcd} == snap), 32'd1);
         check_eq("hold_valid",  32'(out_valid), 32'd1);
         check_eq("hold_ready",  32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("post_valid", 32'(out_valid),   32'd0);
      check_eq("post_ready", 32'(in_ready),    32'd1);
      check_eq("post_keep",  32'(out_int_bcd), 32'(e.ib));
   endtask

   vec_t vecs[$];

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_in_ready",  32'(in_ready),     32'd1);
      check_eq("rst_out_valid", 32'(out_valid),    32'd0);
      check_eq("rst_neg",       32'(out_neg),      32'd0);
      check_eq("rst_int",       32'(out_int_bcd),  32'd0);
      check_eq("rst_frac",      32'(out_frac_bcd), 32'd0);

      vecs.push_back('{32'h0001_0000, 1'b0, 20'h00001, 16'h0000, 0});
      vecs.push_back('{32'hFFFE_8000, 1'b1, 20'h00001, 16'h5000, 0});
      vecs.push_back('{32'h0003_243F, 1'b0, 20'h00003, 16'h1415, 5});
      vecs.push_back('{32'h7FFF_FFFF, 1'b0, 20'h32767, 16'h9999, 0});
      vecs.push_back('{32'h8000_0000, 1'b1, 20'h32768, 16'h0000, 2});
      vecs.push_back('{32'hFFFF_FFFF, 1'b0, 20'h00000, 16'h0000, 0});
      vecs.push_back('{32'h0000_0000, 1'b0, 20'h00000, 16'h0000, 0});
      foreach (vecs[i]) begin
         drive_input(vecs[i].data, '{vecs[i].neg, vecs[i].ib, vecs[i].fb});
         collect(vecs[i].hold);
      end

      for (int i = 0; i < 8; i++) begin
         logic [31:0] d;
         d = $urandom;
         drive_input(d, model(d));
         collect(i % 3);
      end

      // Reset while in INT abandons the conversion.
      drive_input(32'h0005_0000, model(32'h0005_0000));
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check_eq("midrst_in_ready",  32'(in_ready),    32'd1);
      check_eq("midrst_out_valid", 32'(out_valid),   32'd0);
      check_eq("midrst_int",       32'(out_int_bcd), 32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check_eq("midrst_no_output", 32'(seen), 32'd0);
      drive_input(32'h0002_0000, '{1'b0, 20'h00002, 16'h0000});
      collect(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
